// File: rtl/ram_8_arbiter_pkg.sv
// Shared widths, states and request bundle for the ram_8 arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_8_arbiter_pkg;

  localparam int ADDR_WIDTH = 3;
  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 8;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } arb_state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } requester_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

endpackage

// File: rtl/ram_8.sv
// 8 x 16-bit register file: synchronous write, combinational read.
// Latency: write visible the cycle after load; read is same-cycle.
// Backpressure: none, accepts a write every cycle.
module ram_8 (
  input  logic        clock,
  input  logic        load,
  input  logic [2:0]  address,
  input  logic [15:0] data_in,
  output logic [15:0] data_out
);

  logic [15:0] mem [8];

  always_ff @(posedge clock) begin
    if (load) begin
      mem[address] <= data_in;
    end
  end

  assign data_out = mem[address];

endmodule

// File: rtl/ram_8_arbiter.sv
// Round-robin arbiter sharing one ram_8 between requesters A and B, with a clear sweep.
// Latency: read data returned one cycle after accept; clear sweep takes 8 cycles.
// Backpressure: one grant per cycle via combinational ready; no grants while clearing.
module ram_8_arbiter
  import ram_8_arbiter_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = 16'h0000,
  parameter logic                  RESET_PRIORITY = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  a_valid,
  input  logic                  a_write,
  input  logic [ADDR_WIDTH-1:0] a_address,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  output logic                  a_resp_valid,
  output logic [DATA_WIDTH-1:0] a_resp_data,
  input  logic                  b_valid,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  b_resp_valid,
  output logic [DATA_WIDTH-1:0] b_resp_data,
  input  logic                  clear_start,
  output logic                  busy
);

  arb_state_t            state;
  requester_t            prio;
  logic [ADDR_WIDTH-1:0] sweep_cnt;

  req_t                  a_req;
  req_t                  b_req;
  logic                  a_acc;
  logic                  b_acc;
  logic                  ram_load;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign a_req = '{write: a_write, address: a_address, data: a_data};
  assign b_req = '{write: b_write, address: b_address, data: b_data};

  // A clear request in IDLE blocks grants in the same cycle it is seen.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state == IDLE && !clear_start) begin
      if (a_valid && (!b_valid || prio == REQ_A)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  assign a_acc = a_valid && a_ready;
  assign b_acc = b_valid && b_ready;

  always_comb begin
    ram_load  = 1'b0;
    ram_addr  = a_req.address;
    ram_wdata = a_req.data;
    if (state == CLEAR) begin
      ram_load  = 1'b1;
      ram_addr  = sweep_cnt;
      ram_wdata = CLEAR_VALUE;
    end else if (b_acc) begin
      ram_load  = b_req.write;
      ram_addr  = b_req.address;
      ram_wdata = b_req.data;
    end else if (a_acc) begin
      ram_load  = a_req.write;
    end
  end

  ram_8 u_ram (
    .clock    (clock),
    .load     (ram_load),
    .address  (ram_addr),
    .data_in  (ram_wdata),
    .data_out (ram_rdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      prio         <= requester_t'(RESET_PRIORITY);
      sweep_cnt    <= '0;
      a_resp_valid <= 1'b0;
      b_resp_valid <= 1'b0;
      a_resp_data  <= '0;
      b_resp_data  <= '0;
    end else begin
      a_resp_valid <= a_acc && !a_write;
      b_resp_valid <= b_acc && !b_write;
      if (a_acc && !a_write) begin
        a_resp_data <= ram_rdata;
      end
      if (b_acc && !b_write) begin
        b_resp_data <= ram_rdata;
      end
      case (state)
        IDLE: begin
          if (clear_start) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
          end else if (a_acc) begin
            prio <= REQ_B;
          end else if (b_acc) begin
            prio <= REQ_A;
          end
        end
        CLEAR: begin
          // Counter wraps back to zero on the final write.
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == CLEAR);

endmodule
